// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: 32-bit data/instruction words, the canonical NOP,
// and the packed entry carried from fetch to decode.
package fetch_queue_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] instr_t;

    localparam instr_t NOP = 32'h0000_0013;

    typedef struct packed {
        data_t  pc;
        data_t  pc_p4;
        instr_t instr;
        logic   taken;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch->decode handshake bundle for fetch_queue; master is the fetch/decode side,
// slave is the queue itself.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             push_valid;
    logic             push_ready;
    data_t            push_pc;
    data_t            push_pc_p4;
    instr_t           push_instr;
    logic             push_taken;
    logic             pop_valid;
    logic             pop_ready;
    data_t            pop_pc;
    data_t            pop_pc_p4;
    instr_t           pop_instr;
    logic             pop_taken;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, push_valid, push_pc, push_pc_p4, push_instr, push_taken, pop_ready,
        input  push_ready, pop_valid, pop_pc, pop_pc_p4, pop_instr, pop_taken, count
    );

    modport slave (
        input  flush, push_valid, push_pc, push_pc_p4, push_instr, push_taken, pop_ready,
        output push_ready, pop_valid, pop_pc, pop_pc_p4, pop_instr, pop_taken, count
    );

endinterface

// File: rtl/fetch_queue_ptr_ctrl.sv
// Pointer/occupancy bookkeeping for fetch_queue: wrap-around read/write pointers,
// an explicit count so full and empty are never ambiguous, and flush clear.
module fq_ptr_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_en,
    input  logic             pop_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow is the modulo wrap.
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
            else if (pop_en && !push_en) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch->decode instruction buffer (FIFO of pc/pc+4/instr/taken) with flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a push straight to pop_* while empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    fetch_queue_if.slave fq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty;
    logic             push_fire, pop_fire, write_en, bypass_hit, pop_valid;
    fq_entry_t        push_entry, head;
    fq_entry_t        mem_q [DEPTH];

    fq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ptr_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (fq.flush),
        .push_en (write_en),
        .pop_en  (pop_fire),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        push_entry = '{pc: fq.push_pc, pc_p4: fq.push_pc_p4,
                       instr: fq.push_instr, taken: fq.push_taken};
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit = empty & fq.push_valid & ~fq.flush;
`else
        bypass_hit = 1'b0;
`endif
        push_fire = fq.push_valid & ~full & ~fq.flush;
        pop_fire  = ~empty & fq.pop_ready & ~fq.flush;
        // A bypassed entry consumed in the same cycle never lands in storage.
        write_en  = push_fire & ~(bypass_hit & fq.pop_ready);
        pop_valid = (~empty & ~fq.flush) | bypass_hit;
        head      = bypass_hit ? push_entry : mem_q[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (write_en) mem_q[wr_ptr] <= push_entry;
    end

    always_comb begin
        fq.push_ready = ~full;
        fq.pop_valid  = pop_valid;
        fq.pop_pc     = pop_valid ? head.pc    : '0;
        fq.pop_pc_p4  = pop_valid ? head.pc_p4 : '0;
        fq.pop_instr  = pop_valid ? head.instr : NOP;
        fq.pop_taken  = pop_valid & head.taken;
        fq.count      = count;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .fq(bus));

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    bit          chk_en = 1'b0;
    bit          seen40 = 1'b0;
    fq_entry_t   mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic fq_entry_t in_entry();
        return '{pc: bus.push_pc, pc_p4: bus.push_pc_p4, instr: bus.push_instr, taken: bus.push_taken};
    endfunction

    // Reference model: a plain queue updated from the handshake rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mq.delete();
        else begin : upd
            int  n;
            bit  byp, do_pop, do_push;
            n       = mq.size();
            byp     = BYP && n == 0 && bus.push_valid && !bus.flush;
            do_pop  = n > 0 && bus.pop_ready && !bus.flush;
            do_push = bus.push_valid && n < int'(DEPTH) && !bus.flush && !(byp && bus.pop_ready);
            if (bus.flush) mq.delete();
            else begin
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back(in_entry());
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin : cmp
            int        n;
            bit        byp, ev;
            fq_entry_t e;
            n   = mq.size();
            byp = BYP && n == 0 && bus.push_valid && !bus.flush;
            ev  = byp || (n > 0 && !bus.flush);
            e   = '0;
            if (byp) e = in_entry();
            else if (n > 0) e = mq[0];
            chk("m_count",      32'(bus.count), 32'(n));
            chk("m_push_ready", 32'(bus.push_ready), 32'(n != int'(DEPTH)));
            chk("m_pop_valid",  32'(bus.pop_valid), 32'(ev));
            chk("m_pop_pc",     bus.pop_pc,    ev ? e.pc : 32'h0);
            chk("m_pop_pc_p4",  bus.pop_pc_p4, ev ? e.pc_p4 : 32'h0);
            chk("m_pop_instr",  bus.pop_instr, ev ? e.instr : NOP);
            chk("m_pop_taken",  32'(bus.pop_taken), 32'(ev && e.taken));
            if (bus.pop_valid && bus.pop_pc == 32'h40) seen40 = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit pv, input logic [31:0] pc, input bit pr, input bit fl);
        bus.push_valid = pv;
        bus.push_pc    = pc;
        bus.push_pc_p4 = pc + 32'd4;
        bus.push_instr = pc ^ 32'h0000_0013;
        bus.push_taken = pc[2];
        bus.pop_ready  = pr;
        bus.flush      = fl;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst_pop_valid",  32'(bus.pop_valid), 32'd0);
        chk("rst_pop_instr",  bus.pop_instr, NOP);
        chk("rst_count",      32'(bus.count), 32'd0);
        chk("rst_push_ready", 32'(bus.push_ready), 32'd1);

        // Fill, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_push_ready", 32'(bus.push_ready), 32'd0);
        bus.pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("drain_pc", bus.pop_pc, 32'(4 * i));
            cyc();
            chk("drain_count", 32'(bus.count), 32'(3 - i));
        end

        // Full queue with simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, 32'h300, 1'b1, 1'b0);
        #1 chk("fullpp_push_ready", 32'(bus.push_ready), 32'd0);
        chk("fullpp_pop_pc", bus.pop_pc, 32'h200);
        cyc();
        chk("fullpp_count", 32'(bus.count), 32'd3);
        chk("fullpp_push_ready2", 32'(bus.push_ready), 32'd1);
        chk("fullpp_pop_pc2", bus.pop_pc, 32'h204);
        cyc();
        chk("fullpp_count2", 32'(bus.count), 32'd3);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1 chk("fullpp_d0", bus.pop_pc, 32'h208);
        cyc();
        chk("fullpp_d1", bus.pop_pc, 32'h20C);
        cyc();
        chk("fullpp_d2", bus.pop_pc, 32'h300);
        cyc();
        chk("fullpp_empty", 32'(bus.count), 32'd0);

        // Flush with a same-cycle push.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, 32'h40, 1'b0, 1'b1);
        #1 chk("flush_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("flush_pop_instr", bus.pop_instr, NOP);
        chk("flush_pop_pc", bus.pop_pc, 32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1 chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_pop_valid2", 32'(bus.pop_valid), 32'd0);
        cyc();

        // Steady state at count=1 so both pointers wrap twice.
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        cyc();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
            #1 chk("wrap_pc", bus.pop_pc, 32'h100 + 32'(4 * (i - 1)));
            chk("wrap_count", 32'(bus.count), 32'd1);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1 chk("wrap_last", bus.pop_pc, 32'h128);
        cyc();
        chk("wrap_empty", 32'(bus.count), 32'd0);

        // Push into empty queue with decode ready.
        drive(1'b1, 32'h80, 1'b1, 1'b0);
        bus.push_instr = 32'h0050_0093;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_pop_valid", 32'(bus.pop_valid), 32'd1);
        chk("byp_pop_instr", bus.pop_instr, 32'h0050_0093);
        chk("byp_pop_pc", bus.pop_pc, 32'h80);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("byp_count", 32'(bus.count), 32'd0);
`else
        chk("nobyp_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("nobyp_pop_instr", bus.pop_instr, NOP);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1 chk("nobyp_count", 32'(bus.count), 32'd1);
        chk("nobyp_pop_instr2", bus.pop_instr, 32'h0050_0093);
        chk("nobyp_pop_pc", bus.pop_pc, 32'h80);
        cyc();
        chk("nobyp_count2", 32'(bus.count), 32'd0);
`endif

        // Randomized traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                chk("arst_count", 32'(bus.count), 32'd0);
                chk("arst_pop_valid", 32'(bus.pop_valid), 32'd0);
                chk("arst_push_ready", 32'(bus.push_ready), 32'd1);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            cyc();
            bus.push_valid = ($urandom_range(0, 3) != 0);
            bus.push_pc    = $urandom | 32'h8000_0000;
            bus.push_pc_p4 = bus.push_pc + 32'd4;
            bus.push_instr = $urandom;
            bus.push_taken = 1'($urandom_range(0, 1));
            bus.pop_ready  = ($urandom_range(0, 2) != 0);
            bus.flush      = ($urandom_range(0, 15) == 0);
        end
        cyc();
        chk_en = 1'b0;
        chk("no_flushed_0x40", 32'(seen40), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
